// File: rtl/wb_sdram_arb_if.sv
// wb_sdram_arb_if: Wishbone bundle between NUM_MASTERS masters, the arbiter and the SDRAM controller port.
interface wb_sdram_arb_if #(
   parameter int NUM_MASTERS = 3,
   parameter int AW = 23
);
   logic [NUM_MASTERS-1:0] m_cyc_i, m_stb_i, m_we_i;
   logic [NUM_MASTERS*AW-1:0] m_adr_i;
   logic [NUM_MASTERS*32-1:0] m_dat_i;
   logic [NUM_MASTERS*4-1:0] m_sel_i;
   logic [NUM_MASTERS*3-1:0] m_cti_i;
   logic [31:0] m_dat_o;
   logic [NUM_MASTERS-1:0] m_ack_o, m_err_o, gnt_o;
   logic s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [3:0] s_sel_o;
   logic [2:0] s_cti_o;
   logic [31:0] s_dat_i;
   logic s_ack_i;
   modport slave (
      input m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, m_err_o, gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o
   );
   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, s_dat_i, s_ack_i,
      input m_dat_o, m_ack_o, m_err_o, gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o
   );
endinterface

// File: rtl/wb_sdram_arb.sv
// wb_sdram_arb: round-robin Wishbone arbiter holding grant per cycle, with a release gap and an ack watchdog.
module wb_sdram_arb #(
   parameter int NUM_MASTERS = 3,
   parameter int AW = 23,
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic rst,
   wb_sdram_arb_if.slave bus
);
   localparam int N = NUM_MASTERS;
   localparam int LW = N > 1 ? $clog2(N) : 1;
   localparam int WW = $clog2(TIMEOUT + 2);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
   typedef enum logic [2:0] {IDLE = 3'b001, GRANT = 3'b010, RELEASE = 3'b100} state_t;
   state_t state, state_n;
   logic [N-1:0] gnt, gnt_n, req;
   logic [LW-1:0] last, last_n, pick;
   logic [WW-1:0] wd_cnt, wd_n;
   logic in_g, cyc_g, stb_g, wd_hit, leave, found;
   int idx;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt <= '0;
         last <= LW'(N - 1);
         wd_cnt <= '0;
      end else begin
         state <= state_n;
         gnt <= gnt_n;
         last <= last_n;
         wd_cnt <= wd_n;
      end
   end
   // last doubles as the granted index while in GRANT
   always_comb begin
      req = bus.m_cyc_i & bus.m_stb_i;
      pick = last;
      found = 1'b0;
      idx = 0;
      for (int i = 1; i <= N; i++) begin
         idx = int'(last) + i >= N ? int'(last) + i - N : int'(last) + i;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick = LW'(idx);
         end
      end
      in_g = state == GRANT;
      cyc_g = bus.m_cyc_i[last];
      stb_g = bus.m_stb_i[last];
      wd_hit = TIMEOUT != 0 && in_g && cyc_g && stb_g && !bus.s_ack_i && wd_cnt == WD_MAX;
      leave = in_g && (!cyc_g || wd_hit);
      state_n = state == IDLE ? (|req ? GRANT : IDLE) : in_g ? (leave ? RELEASE : GRANT) : IDLE;
      gnt_n = state == IDLE && |req ? N'(1) << pick : in_g && !leave ? gnt : '0;
      last_n = state == IDLE && |req ? pick : last;
      wd_n = !in_g || bus.s_ack_i || leave ? '0 : cyc_g && stb_g && wd_cnt != WD_MAX ? wd_cnt + 1'b1 : wd_cnt;
      bus.gnt_o = gnt;
      bus.s_cyc_o = in_g && cyc_g && !wd_hit;
      bus.s_stb_o = in_g && cyc_g && stb_g && !wd_hit;
      bus.s_we_o = bus.m_we_i[last];
      bus.s_adr_o = bus.m_adr_i[last*AW +: AW];
      bus.s_dat_o = bus.m_dat_i[last*32 +: 32];
      bus.s_sel_o = bus.m_sel_i[last*4 +: 4];
      bus.s_cti_o = bus.m_cti_i[last*3 +: 3];
      bus.m_dat_o = bus.s_dat_i;
      bus.m_ack_o = in_g ? gnt & {N{bus.s_ack_i}} : '0;
      bus.m_err_o = wd_hit ? gnt : '0;
   end
endmodule

// File: tb/tb_wb_sdram_arb.sv
// tb_wb_sdram_arb: directed scenarios for the round-robin SDRAM arbiter (3 masters, 16-clk watchdog).
module tb_wb_sdram_arb;
   localparam int N = 3;
   localparam int AW = 23;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   wb_sdram_arb_if #(.NUM_MASTERS(N), .AW(AW)) bus();
   wb_sdram_arb #(.NUM_MASTERS(N), .AW(AW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic req(input int k, input logic c, input logic s);
      bus.m_cyc_i[k] = c;
      bus.m_stb_i[k] = s;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      bus.m_cyc_i = '1;
      bus.m_stb_i = '1;
      bus.s_ack_i = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cyc: cyc=%b stb=%b, expected 0 0", bus.s_cyc_o, bus.s_stb_o);
      end
      n_chk++;
      if (bus.gnt_o !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_gnt: got %b, expected 000", bus.gnt_o);
      end
      n_chk++;
      if (bus.m_ack_o !== 3'b000 || bus.m_err_o !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ack_err: ack=%b err=%b, expected 000 000", bus.m_ack_o, bus.m_err_o);
      end
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.s_ack_i = 1'b0;
      tick;
      rst = 1'b0;
      tick;
   endtask
   task automatic test_single_read;
      bus.m_adr_i[0 +: AW] = 23'h12345;
      bus.m_sel_i[3:0] = 4'hf;
      bus.m_we_i[0] = 1'b0;
      req(0, 1'b1, 1'b1);
      @(negedge clk);
      n_chk++;
      if (bus.s_cyc_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_latency: s_cyc_o=%b, expected 0", bus.s_cyc_o);
      end
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.gnt_o !== 3'b001 || bus.s_adr_o !== 23'h12345 || bus.s_sel_o !== 4'hf || bus.m_ack_o !== 3'b000) begin
         n_fail++;
         $display("FAIL single_grant: cyc=%b stb=%b gnt=%b adr=%h sel=%h ack=%b, expected 1 1 001 12345 f 000",
                  bus.s_cyc_o, bus.s_stb_o, bus.gnt_o, bus.s_adr_o, bus.s_sel_o, bus.m_ack_o);
      end
      tick;
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = 32'hdeadbeef;
      @(negedge clk);
      n_chk++;
      if (bus.m_ack_o !== 3'b001 || bus.m_dat_o !== 32'hdeadbeef) begin
         n_fail++;
         $display("FAIL single_ack: ack=%b dat=%h, expected 001 deadbeef", bus.m_ack_o, bus.m_dat_o);
      end
      tick;
      bus.s_ack_i = 1'b0;
      req(0, 1'b0, 1'b0);
      @(negedge clk);
      n_chk++;
      if (bus.s_cyc_o !== 1'b0 || bus.gnt_o !== 3'b001) begin
         n_fail++;
         $display("FAIL single_drop: cyc=%b gnt=%b, expected 0 001", bus.s_cyc_o, bus.gnt_o);
      end
      tick;
      bus.s_ack_i = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.gnt_o !== 3'b000 || bus.s_cyc_o !== 1'b0 || bus.m_ack_o !== 3'b000) begin
         n_fail++;
         $display("FAIL stray_ack: gnt=%b cyc=%b ack=%b, expected 000 0 000", bus.gnt_o, bus.s_cyc_o, bus.m_ack_o);
      end
      tick;
      bus.s_ack_i = 1'b0;
   endtask
   task automatic test_round_robin;
      int ord[4] = '{0, 1, 2, 0};
      logic [2:0] e;
      rst = 1'b1;
      bus.m_cyc_i = '1;
      bus.m_stb_i = '1;
      tick;
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         e = 3'(1 << ord[s]);
         tick;
         @(negedge clk);
         n_chk++;
         if (bus.gnt_o !== e || bus.s_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_gnt%0d: gnt=%b cyc=%b, expected %b 1", s, bus.gnt_o, bus.s_cyc_o, e);
         end
         tick;
         bus.s_ack_i = 1'b1;
         @(negedge clk);
         n_chk++;
         if (bus.m_ack_o !== e) begin
            n_fail++;
            $display("FAIL rr_ack%0d: got %b, expected %b", s, bus.m_ack_o, e);
         end
         tick;
         bus.s_ack_i = 1'b0;
         req(ord[s], 1'b0, 1'b0);
         tick;
         if (s < 3) req(ord[s], 1'b1, 1'b1);
         else begin
            bus.m_cyc_i = '0;
            bus.m_stb_i = '0;
         end
         @(negedge clk);
         n_chk++;
         if (bus.gnt_o !== 3'b000 || bus.s_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_gap%0d: gnt=%b cyc=%b, expected 000 0", s, bus.gnt_o, bus.s_cyc_o);
         end
         tick;
      end
   endtask
   task automatic test_burst;
      logic [2:0] cti;
      bus.m_we_i[1] = 1'b1;
      req(1, 1'b1, 1'b1);
      req(2, 1'b1, 1'b1);
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.gnt_o !== 3'b010) begin
         n_fail++;
         $display("FAIL burst_gnt: got %b, expected 010", bus.gnt_o);
      end
      tick;
      for (int b = 0; b < 8; b++) begin
         cti = b == 7 ? 3'b111 : 3'b010;
         bus.m_adr_i[AW +: AW] = 23'h100 + 23'(b);
         bus.m_cti_i[3 +: 3] = cti;
         bus.m_dat_i[32 +: 32] = 32'h11110000 + 32'(b);
         bus.s_ack_i = 1'b1;
         @(negedge clk);
         n_chk++;
         if (bus.m_ack_o !== 3'b010 || bus.gnt_o !== 3'b010 || bus.s_adr_o !== 23'h100 + 23'(b) || bus.s_cti_o !== cti || bus.s_dat_o !== 32'h11110000 + 32'(b) || bus.s_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_beat%0d: ack=%b gnt=%b adr=%h cti=%b dat=%h we=%b, expected 010 010 %h %b %h 1",
                     b, bus.m_ack_o, bus.gnt_o, bus.s_adr_o, bus.s_cti_o, bus.s_dat_o, bus.s_we_o, 23'h100 + 23'(b), cti, 32'h11110000 + 32'(b));
         end
         tick;
      end
      bus.s_ack_i = 1'b0;
      req(1, 1'b0, 1'b0);
      @(negedge clk);
      n_chk++;
      if (bus.s_cyc_o !== 1'b0 || bus.m_ack_o !== 3'b000) begin
         n_fail++;
         $display("FAIL burst_end: cyc=%b ack=%b, expected 0 000", bus.s_cyc_o, bus.m_ack_o);
      end
      tick;
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.gnt_o !== 3'b000) begin
         n_fail++;
         $display("FAIL burst_wait: gnt=%b, expected 000", bus.gnt_o);
      end
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.gnt_o !== 3'b100 || bus.s_cyc_o !== 1'b1) begin
         n_fail++;
         $display("FAIL burst_next: gnt=%b cyc=%b, expected 100 1", bus.gnt_o, bus.s_cyc_o);
      end
      tick;
      bus.s_ack_i = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.m_ack_o !== 3'b100) begin
         n_fail++;
         $display("FAIL burst_m2_ack: got %b, expected 100", bus.m_ack_o);
      end
      tick;
      bus.s_ack_i = 1'b0;
      req(2, 1'b0, 1'b0);
      tick;
      tick;
   endtask
   task automatic test_timeout;
      bus.s_ack_i = 1'b0;
      req(0, 1'b1, 1'b1);
      req(1, 1'b1, 1'b1);
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.gnt_o !== 3'b001 || bus.s_cyc_o !== 1'b1 || bus.m_err_o !== 3'b000) begin
         n_fail++;
         $display("FAIL to_gnt: gnt=%b cyc=%b err=%b, expected 001 1 000", bus.gnt_o, bus.s_cyc_o, bus.m_err_o);
      end
      for (int c = 1; c < TO - 1; c++) begin
         tick;
         @(negedge clk);
         n_chk++;
         if (bus.m_err_o !== 3'b000 || bus.s_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL to_early%0d: err=%b cyc=%b, expected 000 1", c, bus.m_err_o, bus.s_cyc_o);
         end
      end
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.m_err_o !== 3'b001 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
         n_fail++;
         $display("FAIL to_err: err=%b cyc=%b stb=%b, expected 001 0 0", bus.m_err_o, bus.s_cyc_o, bus.s_stb_o);
      end
      tick;
      req(0, 1'b0, 1'b0);
      @(negedge clk);
      n_chk++;
      if (bus.m_err_o !== 3'b000 || bus.gnt_o !== 3'b000) begin
         n_fail++;
         $display("FAIL to_release: err=%b gnt=%b, expected 000 000", bus.m_err_o, bus.gnt_o);
      end
      tick;
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.gnt_o !== 3'b010) begin
         n_fail++;
         $display("FAIL to_next: gnt=%b, expected 010", bus.gnt_o);
      end
   endtask
   task automatic test_lock;
      tick;
      req(1, 1'b1, 1'b0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_chk++;
         if (bus.gnt_o !== 3'b010 || bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b0 || bus.m_err_o !== 3'b000) begin
            n_fail++;
            $display("FAIL lock%0d: gnt=%b cyc=%b stb=%b err=%b, expected 010 1 0 000", c, bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.m_err_o);
         end
         tick;
      end
      req(1, 1'b1, 1'b1);
      @(negedge clk);
      n_chk++;
      if (bus.m_err_o !== 3'b000 || bus.s_stb_o !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_wd_idle: err=%b stb=%b, expected 000 1", bus.m_err_o, bus.s_stb_o);
      end
      tick;
      bus.s_ack_i = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.m_ack_o !== 3'b010) begin
         n_fail++;
         $display("FAIL lock_ack: got %b, expected 010", bus.m_ack_o);
      end
      tick;
      bus.s_ack_i = 1'b0;
      req(1, 1'b0, 1'b0);
      tick;
      tick;
   endtask
   task automatic test_reset_mid_burst;
      bus.m_cti_i[3 +: 3] = 3'b010;
      req(1, 1'b1, 1'b1);
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.gnt_o !== 3'b010) begin
         n_fail++;
         $display("FAIL rb_gnt: got %b, expected 010", bus.gnt_o);
      end
      tick;
      bus.s_ack_i = 1'b1;
      req(0, 1'b1, 1'b1);
      req(2, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_chk++;
      if (bus.s_cyc_o !== 1'b0 || bus.gnt_o !== 3'b000 || bus.m_ack_o !== 3'b000) begin
         n_fail++;
         $display("FAIL rb_async: cyc=%b gnt=%b ack=%b, expected 0 000 000", bus.s_cyc_o, bus.gnt_o, bus.m_ack_o);
      end
      bus.s_ack_i = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      @(negedge clk);
      n_chk++;
      if (bus.gnt_o !== 3'b001) begin
         n_fail++;
         $display("FAIL rb_first: gnt=%b, expected 001", bus.gnt_o);
      end
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
   endtask
   initial begin
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_we_i = '0;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_sel_i = '0;
      bus.m_cti_i = '0;
      bus.s_dat_i = '0;
      bus.s_ack_i = 1'b0;
      test_reset;
      test_single_read;
      test_round_robin;
      test_burst;
      test_timeout;
      test_lock;
      test_reset_mid_burst;
      tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
